// File: rtl/apb_adv_timer_cfg_ctrl_if.sv
// APB master bus bundle used by the advanced-timer configuration controller.
// Ports: paddr/psel/penable/pwrite/pwdata (master->slave), pready/pslverr (slave->master).
interface apb_adv_timer_cfg_ctrl_if;
    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, pslverr
    );
endinterface

// File: rtl/apb_adv_timer_cfg_ctrl.sv
// Programs one advanced-timer channel over APB: full start sequence or stop-only.
// Ports: clk/reset, req_* request handshake, apb master bus, busy/done/err/err_timeout status.
module apb_adv_timer_cfg_ctrl #(
    parameter int NUM_TIMERS     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_stop,
    input  logic [1:0]  req_timer,
    input  logic [7:0]  req_prescaler,
    input  logic [15:0] req_th_lo,
    input  logic [15:0] req_th_hi,
    input  logic [15:0] req_ch0_th,
    input  logic [2:0]  req_ch0_mode,
    apb_adv_timer_cfg_ctrl_if.master apb,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_n;
    logic        stop_q;
    logic [1:0]  timer_q;
    logic [7:0]  presc_q;
    logic [15:0] th_lo_q;
    logic [15:0] th_hi_q;
    logic [15:0] ch0_th_q;
    logic [2:0]  ch0_mode_q;
    logic [1:0]  idx_q;
    logic [7:0]  wait_q;
    logic        err_q, err_n;
    logic        to_q, to_n;

    logic        accept;
    logic        bad_timer;
    logic        last_wr;
    logic [5:0]  offset;
    logic [31:0] wdata;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign bad_timer = {30'd0, req_timer} >= NUM_TIMERS[31:0];
    // A stop sequence is a single CMD write; a full one ends on write 3.
    assign last_wr   = stop_q || (idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        err_n   = 1'b0;
        to_n    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = bad_timer ? DONE : SETUP;
                    err_n   = bad_timer;
                end
            end
            SETUP: begin
                state_n = ACCESS;
            end
            ACCESS: begin
                if (apb.pready) begin
                    if (apb.pslverr) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                    end else if (last_wr) begin
                        state_n = DONE;
                    end else begin
                        state_n = SETUP;
                    end
                end else if (wait_q == TO_LAST) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    to_n    = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stop_q     <= 1'b0;
            timer_q    <= '0;
            presc_q    <= '0;
            th_lo_q    <= '0;
            th_hi_q    <= '0;
            ch0_th_q   <= '0;
            ch0_mode_q <= '0;
            idx_q      <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            // Error flags are latched on the edge entering DONE and held
            // through the DONE cycle; err_n is 0 on every other edge.
            err_q <= err_n;
            to_q  <= to_n;
            if (accept) begin
                stop_q     <= req_stop;
                timer_q    <= req_timer;
                presc_q    <= req_prescaler;
                th_lo_q    <= req_th_lo;
                th_hi_q    <= req_th_hi;
                ch0_th_q   <= req_ch0_th;
                ch0_mode_q <= req_ch0_mode;
                idx_q      <= '0;
            end else if (state_q == ACCESS && apb.pready && !apb.pslverr) begin
                idx_q <= idx_q + 2'd1;
            end
            if (state_n == SETUP) begin
                wait_q <= '0;
            end else if (state_q == ACCESS && !apb.pready) begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end

    always_comb begin
        offset = 6'h00;
        wdata  = 32'h0;
        if (stop_q) begin
            offset = 6'h00;
            wdata  = 32'h2;
        end else begin
            unique case (idx_q)
                2'd0: begin
                    offset = 6'h04;
                    wdata  = {8'h0, presc_q, 16'h0};
                end
                2'd1: begin
                    offset = 6'h08;
                    wdata  = {th_hi_q, th_lo_q};
                end
                2'd2: begin
                    offset = 6'h0C;
                    wdata  = {13'h0, ch0_mode_q, ch0_th_q};
                end
                default: begin
                    offset = 6'h00;
                    wdata  = 32'h1;
                end
            endcase
        end
    end

    // Address and data only depend on captured fields and the write index,
    // so they stay stable from SETUP through the end of ACCESS.
    assign apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign apb.penable = (state_q == ACCESS);
    assign apb.pwrite  = apb.psel;
    assign apb.paddr   = apb.psel ? {4'h0, timer_q, offset} : 12'h0;
    assign apb.pwdata  = apb.psel ? wdata : 32'h0;

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign err         = done && err_q;
    assign err_timeout = done && to_q;

endmodule
